// File: rtl/pacessor_mc.sv
// ---------------------------------------------------------------------------
// pacessor_mc -- parametrised multi-cycle accumulator-style core
//
// Purpose:
//   Fetches 32-bit instruction words over a req/ack handshake and executes
//   them one at a time with a BOOT/FETCH/EXEC/OUT_WAIT/HALT state machine.
//   Holds NREG general registers of DW bits, Z/C flags, a sticky illegal-
//   opcode flag and a valid/ready output port.
//
//   Instruction fields:
//     op = inst[31:24]  rd = inst[19:16]  ra = inst[11:8]  rb = inst[3:0]
//     imm = inst[15:0] (truncated/zero-extended to DW)  target = inst[AW-1:0]
//   Register indices use only the low log2(NREG) bits of rd/ra/rb.
//
// Parameters:
//   DW      datapath / register width (4..16)
//   AW      instruction address width, PC wraps modulo 2^AW
//   NREG    register count, power of two (2..16)
//   PC_STEP PC increment per instruction
//
// Ports:
//   clk          in   rising-edge clock
//   rst_master_n in   asynchronous active-low reset
//   imem_req     out  fetch request, high only while in FETCH
//   imem_addr    out  fetch address (always equals PC)
//   imem_ack     in   fetch accepted; imem_rdata valid in the same cycle
//   imem_rdata   in   instruction word
//   out_data     out  output port data (keeps last value after accept)
//   out_valid    out  out_data valid
//   out_ready    in   consumer ready
//   halted       out  core stopped by HALT
//   illegal      out  sticky: an undefined opcode was executed
//   pc_o         out  current PC
// ---------------------------------------------------------------------------
module pacessor_mc #(
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int NREG    = 16,
  parameter int PC_STEP = 4
) (
  input  logic          clk,
  input  logic          rst_master_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          halted,
  output logic          illegal,
  output logic [AW-1:0] pc_o
);

  localparam int RIW = $clog2(NREG);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_SHL  = 8'h06;
  localparam logic [7:0] OP_LDI  = 8'h07;
  localparam logic [7:0] OP_OUT  = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h09;
  localparam logic [7:0] OP_JZ   = 8'h0A;
  localparam logic [7:0] OP_JC   = 8'h0B;
  localparam logic [7:0] OP_HALT = 8'h0C;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_OUT_WAIT,
    S_HALT
  } state_t;

  // -------------------------------------------------------------------------
  // Architectural state
  // -------------------------------------------------------------------------
  state_t          state_q;
  logic [AW-1:0]   pc_q;
  logic [31:0]     ir_q;
  logic            z_q;
  logic            c_q;
  logic            req_q;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic            halted_q;
  logic            illegal_q;
  logic [DW-1:0]   regs_q [NREG];

  // -------------------------------------------------------------------------
  // Decode: all fields come straight from the instruction register, so the
  // register-file reads below are combinational during EXEC.
  // -------------------------------------------------------------------------
  logic [7:0]     op;
  logic [RIW-1:0] rd_idx;
  logic [RIW-1:0] ra_idx;
  logic [RIW-1:0] rb_idx;
  logic [DW-1:0]  imm;
  logic [AW-1:0]  target;
  logic [DW-1:0]  ra_val;
  logic [DW-1:0]  rb_val;
  logic           op_legal;

  assign op       = ir_q[31:24];
  assign rd_idx   = ir_q[16 +: RIW];
  assign ra_idx   = ir_q[8 +: RIW];
  assign rb_idx   = ir_q[0 +: RIW];
  assign imm      = DW'(ir_q[15:0]);
  assign target   = ir_q[AW-1:0];
  assign ra_val   = regs_q[ra_idx];
  assign rb_val   = regs_q[rb_idx];
  assign op_legal = (op <= OP_HALT);

  // Several IR bits are don't-care for some parameter sets (e.g. bits 23:20
  // and the high bits of each register field); fold them here so every bit
  // of the instruction register is visibly consumed.
  logic unused_ir;
  assign unused_ir = ^ir_q;

  // -------------------------------------------------------------------------
  // ALU: one extra bit on top carries C. For SUB the top bit is the unsigned
  // borrow, for SHL it is the bit shifted out.
  // -------------------------------------------------------------------------
  logic [DW:0]   alu_wide_d;
  logic [DW-1:0] alu_res_d;
  logic          alu_c_d;
  logic          alu_wr_d;

  always_comb begin
    alu_wide_d = '0;
    alu_wr_d   = 1'b1;
    case (op)
      OP_ADD:  alu_wide_d = {1'b0, ra_val} + {1'b0, rb_val};
      OP_SUB:  alu_wide_d = {(ra_val < rb_val), ra_val - rb_val};
      OP_AND:  alu_wide_d = {1'b0, ra_val & rb_val};
      OP_OR:   alu_wide_d = {1'b0, ra_val | rb_val};
      OP_XOR:  alu_wide_d = {1'b0, ra_val ^ rb_val};
      OP_SHL:  alu_wide_d = {ra_val, 1'b0};
      default: alu_wr_d   = 1'b0;
    endcase
  end

  assign alu_res_d = alu_wide_d[DW-1:0];
  assign alu_c_d   = alu_wide_d[DW];

  // -------------------------------------------------------------------------
  // Next PC at the end of EXEC. OUT and HALT leave the PC alone: OUT
  // advances it only when the consumer accepts the data.
  // -------------------------------------------------------------------------
  logic [AW-1:0] pc_inc_d;
  logic [AW-1:0] pc_exec_d;

  assign pc_inc_d = pc_q + AW'(PC_STEP);

  always_comb begin
    pc_exec_d = pc_inc_d;
    case (op)
      OP_JMP:           pc_exec_d = target;
      OP_JZ:            if (z_q) pc_exec_d = target;
      OP_JC:            if (c_q) pc_exec_d = target;
      OP_OUT, OP_HALT:  pc_exec_d = pc_q;
      default:          pc_exec_d = pc_inc_d;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM and all architectural registers. Outputs are registered and
  // updated together with the state they belong to.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_master_n) begin
    if (!rst_master_n) begin
      state_q     <= S_BOOT;
      pc_q        <= '0;
      ir_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      req_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end

        S_FETCH: begin
          // Wait states are unbounded: nothing moves until the ack edge.
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end
        end

        S_EXEC: begin
          pc_q    <= pc_exec_d;
          state_q <= S_FETCH;
          req_q   <= 1'b1;

          if (alu_wr_d) begin
            regs_q[rd_idx] <= alu_res_d;
            z_q            <= (alu_res_d == '0);
            c_q            <= alu_c_d;
          end

          if (op == OP_LDI) begin
            regs_q[rd_idx] <= imm;
          end

          if (op == OP_OUT) begin
            out_data_q  <= ra_val;
            out_valid_q <= 1'b1;
            req_q       <= 1'b0;
            state_q     <= S_OUT_WAIT;
          end

          if (op == OP_HALT) begin
            halted_q <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= S_HALT;
          end

          // Undefined opcodes otherwise behave exactly like NOP.
          if (!op_legal) begin
            illegal_q <= 1'b1;
          end
        end

        S_OUT_WAIT: begin
          // out_data is deliberately not cleared on accept.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_inc_d;
            req_q       <= 1'b1;
            state_q     <= S_FETCH;
          end
        end

        S_HALT: begin
          req_q <= 1'b0;
        end

        default: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_pacessor_mc.sv
// ---------------------------------------------------------------------------
// tb_pacessor_mc -- self-checking bench for pacessor_mc
//
// Two cores share clock and reset: u_a with default parameters and u_b with
// DW=16 / NREG=4. 'sel' routes the handshake inputs to one core and muxes its
// outputs onto common observation signals. Instructions are supplied on the
// fly at each fetch; an instruction-level model predicts PC, registers,
// flags and output data.
// ---------------------------------------------------------------------------
module tb_pacessor_mc;

  logic clk;
  logic rst_n;
  logic sel;
  logic ack;
  logic ready;
  logic [31:0] rdata;

  logic       req_a, req_b, oval_a, oval_b, halt_a, halt_b, ill_a, ill_b;
  logic [4:0] addr_a, addr_b, pc_a, pc_b;
  logic [7:0] od_a;
  logic [15:0] od_b;
  logic       ack_a, ack_b, rdy_a, rdy_b;

  logic        req, oval, halt, ill;
  logic [4:0]  addr, pc;
  logic [15:0] odata;

  assign ack_a = ack & ~sel;
  assign ack_b = ack & sel;
  assign rdy_a = ready & ~sel;
  assign rdy_b = ready & sel;

  assign req   = sel ? req_b  : req_a;
  assign oval  = sel ? oval_b : oval_a;
  assign halt  = sel ? halt_b : halt_a;
  assign ill   = sel ? ill_b  : ill_a;
  assign addr  = sel ? addr_b : addr_a;
  assign pc    = sel ? pc_b   : pc_a;
  assign odata = sel ? od_b   : {8'h00, od_a};

  pacessor_mc u_a (
    .clk          (clk),
    .rst_master_n (rst_n),
    .imem_req     (req_a),
    .imem_addr    (addr_a),
    .imem_ack     (ack_a),
    .imem_rdata   (rdata),
    .out_data     (od_a),
    .out_valid    (oval_a),
    .out_ready    (rdy_a),
    .halted       (halt_a),
    .illegal      (ill_a),
    .pc_o         (pc_a)
  );

  pacessor_mc #(.DW(16), .AW(5), .NREG(4), .PC_STEP(4)) u_b (
    .clk          (clk),
    .rst_master_n (rst_n),
    .imem_req     (req_b),
    .imem_addr    (addr_b),
    .imem_ack     (ack_b),
    .imem_rdata   (rdata),
    .out_data     (od_b),
    .out_valid    (oval_b),
    .out_ready    (rdy_b),
    .halted       (halt_b),
    .illegal      (ill_b),
    .pc_o         (pc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_mis;

  // Instruction-level model state
  int unsigned m_reg [16];
  int unsigned m_pc;
  int unsigned m_dw;
  int unsigned m_nreg;
  bit          m_z;
  bit          m_c;
  bit          m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    m_pc  = 0;
    m_z   = 1'b0;
    m_c   = 1'b0;
    m_ill = 1'b0;
  endfunction

  task automatic wait_req();
    for (int n = 0; n < 40 && req !== 1'b1; n++) @(negedge clk);
    chk("fetch_req", 32'(req), 32'd1);
  endtask

  // Asynchronous reset placed away from clock edges; outputs must drop
  // before any edge arrives.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",     32'(req),   32'd0);
    chk("rst_valid",   32'(oval),  32'd0);
    chk("rst_halted",  32'(halt),  32'd0);
    chk("rst_illegal", 32'(ill),   32'd0);
    chk("rst_pc",      32'(pc),    32'd0);
    chk("rst_odata",   32'(odata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1 chk("boot_req", 32'(req), 32'd0);
    @(negedge clk);
    chk("boot_fetch_req", 32'(req), 32'd1);
    chk("boot_addr", 32'(addr), 32'd0);
    $display("[%0t] reset released (core %0d)", $time, sel);
  endtask

  // Fetch and execute one instruction, checking the handshakes on the way.
  // fdelay: wait states before ack; rdelay: cycles out_ready is held low.
  // abort_out: leave an OUT sitting in OUT_WAIT without accepting it.
  task automatic run_instr(input logic [31:0] w, input int fdelay, input int rdelay,
                           input bit abort_out);
    int unsigned rd, ra, rb, a, b, res, mask, tgt, nxt, outv;
    int kind;
    wait_req();
    chk("fetch_addr", 32'(addr), m_pc);
    chk("pc_o", 32'(pc), m_pc);
    chk("illegal_flag", 32'(ill), 32'(m_ill));
    $display("[%0t] core%0d pc=%02h instr=%08h fdly=%0d", $time, sel, m_pc, w, fdelay);
    for (int i = 0; i < fdelay; i++) begin
      @(negedge clk);
      chk("stall_req", 32'(req), 32'd1);
      chk("stall_addr", 32'(addr), m_pc);
    end
    ack   = 1'b1;
    rdata = w;
    @(posedge clk);
    #1;
    ack   = 1'b0;
    rdata = $urandom;

    rd   = {28'd0, w[19:16]} % m_nreg;
    ra   = {28'd0, w[11:8]} % m_nreg;
    rb   = {28'd0, w[3:0]} % m_nreg;
    a    = m_reg[ra];
    b    = m_reg[rb];
    mask = (32'd1 << m_dw) - 32'd1;
    tgt  = {27'd0, w[4:0]};
    nxt  = (m_pc + 32'd4) % 32'd32;
    kind = 0;
    outv = 0;
    case (w[31:24])
      8'h00: m_pc = nxt;
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06: begin
        case (w[31:24])
          8'h01:   begin res = a + b; m_c = (res > mask); end
          8'h02:   begin res = a - b; m_c = (a < b); end
          8'h03:   begin res = a & b; m_c = 1'b0; end
          8'h04:   begin res = a | b; m_c = 1'b0; end
          8'h05:   begin res = a ^ b; m_c = 1'b0; end
          default: begin res = a * 2; m_c = (res > mask); end
        endcase
        res = res & mask;
        m_z = (res == 32'd0);
        m_reg[rd] = res;
        m_pc = nxt;
      end
      8'h07: begin m_reg[rd] = {16'd0, w[15:0]} & mask; m_pc = nxt; end
      8'h08: begin kind = 1; outv = a; end
      8'h09: m_pc = tgt;
      8'h0A: m_pc = m_z ? tgt : nxt;
      8'h0B: m_pc = m_c ? tgt : nxt;
      8'h0C: kind = 2;
      default: begin m_ill = 1'b1; m_pc = nxt; end
    endcase

    if (kind == 0) begin
      @(negedge clk);
      chk("exec_req", 32'(req), 32'd0);
      @(negedge clk);
      chk("refetch_req", 32'(req), 32'd1);
      chk("next_addr", 32'(addr), m_pc);
    end else if (kind == 1) begin
      @(negedge clk);
      chk("out_pre_valid", 32'(oval), 32'd0);
      @(negedge clk);
      chk("out_valid", 32'(oval), 32'd1);
      chk("out_data", 32'(odata), outv);
      if (!abort_out) begin
        for (int i = 0; i < rdelay; i++) begin
          @(negedge clk);
          chk("out_hold_valid", 32'(oval), 32'd1);
          chk("out_hold_data", 32'(odata), outv);
          chk("out_hold_pc", 32'(pc), m_pc);
          chk("out_hold_req", 32'(req), 32'd0);
        end
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        m_pc = nxt;
        @(negedge clk);
        chk("out_drop_valid", 32'(oval), 32'd0);
        chk("out_keep_data", 32'(odata), outv);
        chk("out_next_req", 32'(req), 32'd1);
        chk("out_next_addr", 32'(addr), m_pc);
      end
    end else begin
      @(negedge clk);
      @(negedge clk);
      chk("halted", 32'(halt), 32'd1);
      chk("halt_req", 32'(req), 32'd0);
      chk("halt_pc", 32'(pc), m_pc);
      repeat (4) begin
        @(negedge clk);
        chk("halt_stay_req", 32'(req), 32'd0);
        chk("halt_stay", 32'(halt), 32'd1);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned r;
    w = $urandom;
    r = $urandom_range(0, 99);
    if (r < 20)      w[31:24] = 8'h07;
    else if (r < 40) w[31:24] = 8'h08;
    else if (r < 43) w[31:24] = 8'($urandom_range(13, 255));
    else             w[31:24] = 8'($urandom_range(0, 11));
    return w;
  endfunction

  task automatic random_run(input int count);
    for (int i = 0; i < count; i++) begin
      run_instr(rand_instr(), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 4)), 1'b0);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    rst_n  = 1'b1;
    sel    = 1'b0;
    ack    = 1'b0;
    ready  = 1'b0;
    rdata  = '0;
    m_dw   = 8;
    m_nreg = 16;
    model_reset();

    // Basic program: 5 + 6 sent to the output port, then HALT at 0x10.
    apply_reset();
    run_instr(32'h07020005, 0, 0, 1'b0);
    run_instr(32'h07050006, 0, 0, 1'b0);
    run_instr(32'h01030205, 0, 0, 1'b0);
    run_instr(32'h08000300, 0, 0, 1'b0);
    chk("prog_pc_before_halt", 32'(pc), 32'h10);
    run_instr(32'h0C000000, 0, 0, 1'b0);

    // Flags, jumps, PC wrap, handshake stalls and the illegal opcode.
    apply_reset();
    run_instr(32'h070100FF, 0, 0, 1'b0);
    run_instr(32'h07020001, 0, 0, 1'b0);
    run_instr(32'h01030102, 0, 0, 1'b0);   // r3 = 0x00, Z=1, C=1
    run_instr(32'h08000300, 0, 0, 1'b0);
    run_instr(32'h0A00001C, 3, 0, 1'b0);   // JZ taken, delayed ack
    chk("jz_taken_addr", 32'(addr), 32'h1C);
    run_instr(32'h00000000, 0, 0, 1'b0);   // NOP at 0x1C wraps to 0
    chk("wrap_addr", 32'(addr), 32'h00);
    run_instr(32'h02040201, 0, 0, 1'b0);   // r4 = 0x02, C=1, Z=0
    run_instr(32'h0A000010, 0, 0, 1'b0);   // JZ falls through
    run_instr(32'h0B000014, 0, 0, 1'b0);   // JC taken
    run_instr(32'h08000400, 0, 5, 1'b0);   // OUT r4 with 5 stall cycles
    run_instr(32'hFF040102, 0, 0, 1'b0);   // illegal, registers untouched
    run_instr(32'h08000400, 3, 0, 1'b0);
    run_instr(32'h07060077, 0, 0, 1'b0);
    run_instr(32'h08000600, 0, 2, 1'b0);
    chk("illegal_sticky", 32'(ill), 32'd1);

    random_run(250);

    // Reset in the middle of OUT_WAIT, then check registers came back zero.
    run_instr(32'h0707005A, 0, 0, 1'b0);
    run_instr(32'h08000700, 0, 0, 1'b1);
    apply_reset();
    run_instr(32'h08000700, 0, 0, 1'b0);

    // Reset while a fetch is outstanding.
    run_instr(32'h07010033, 0, 0, 1'b0);
    wait_req();
    apply_reset();
    run_instr(32'h08000100, 1, 1, 1'b0);

    // Reset out of HALT.
    run_instr(32'h0C000000, 0, 0, 1'b0);
    apply_reset();

    // Wide core: DW=16, NREG=4.
    sel    = 1'b1;
    m_dw   = 16;
    m_nreg = 4;
    apply_reset();
    run_instr(32'h07061234, 0, 0, 1'b0);   // rd field 6 -> r2
    run_instr(32'h08000200, 0, 0, 1'b0);
    run_instr(32'h08000600, 0, 0, 1'b0);   // ra field 6 also reads r2
    run_instr(32'h07058001, 0, 0, 1'b0);   // r1 = 0x8001
    run_instr(32'h06030100, 0, 0, 1'b0);   // SHL -> 0x0002, C=1
    run_instr(32'h0B000014, 0, 0, 1'b0);   // JC taken
    run_instr(32'h08000300, 0, 1, 1'b0);
    random_run(150);
    run_instr(32'h0C000000, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
